// File: rtl/multicycle_alu.sv
// Purpose: EX-stage ALU; simple ops registered in one cycle, MULT/MULTU/DIV/DIVU iterate (shift-add / restoring divide) into HI/LO.
// Latency: simple ops strobe out_valid in the cycle after accept; mul/div strobe WIDTH+2 cycles after accept.
// Backpressure: in_ready is low while a mul/div is in flight; in_valid during that time is dropped, not queued.
module multicycle_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int OP_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    alu_op,
    input  logic [WIDTH-1:0]   data_in1,
    input  logic [WIDTH-1:0]   data_in2,
    input  logic [SHAMT_W-1:0] shift_amount,
    output logic               out_valid,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               zero,
    output logic               div_by_zero,
    output logic               busy
);

    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(5'b00000);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(5'b00001);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(5'b00010);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(5'b00011);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(5'b00100);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(5'b00101);
    localparam logic [OP_W-1:0] OP_MULT  = OP_W'(5'b00110);
    localparam logic [OP_W-1:0] OP_DIV   = OP_W'(5'b00111);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(5'b01000);
    localparam logic [OP_W-1:0] OP_NOR   = OP_W'(5'b01001);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(5'b01010);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(5'b01011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5'b01101);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(5'b01110);
    localparam logic [OP_W-1:0] OP_BLEZ  = OP_W'(5'b01111);
    localparam logic [OP_W-1:0] OP_BGTZ  = OP_W'(5'b10000);
    localparam logic [OP_W-1:0] OP_BGEZ  = OP_W'(5'b10001);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(5'b10010);
    localparam logic [OP_W-1:0] OP_MULTU = OP_W'(5'b10011);
    localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(5'b10100);
    localparam logic [OP_W-1:0] OP_SLLV  = OP_W'(5'b11001);
    localparam logic [OP_W-1:0] OP_SRLV  = OP_W'(5'b11010);
    localparam logic [OP_W-1:0] OP_SRAV  = OP_W'(5'b11011);

    localparam logic [SHAMT_W-1:0] LAST_ITER = SHAMT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX
    } state_t;

    state_t               state;
    logic [SHAMT_W-1:0]   cnt;
    logic                 op_div;     // 1: divide in flight, 0: multiply
    logic                 neg_lo;     // negate product / quotient at FIX
    logic                 neg_hi;     // negate remainder at FIX (dividend sign)
    logic                 dbz_pend;   // divisor was zero
    logic [WIDTH-1:0]     opnd;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0]     acc_hi;     // partial product high / remainder
    logic [WIDTH-1:0]     acc_lo;     // multiplier bits / dividend->quotient bits

    logic [WIDTH-1:0]     alu_res;
    logic                 is_mul;
    logic                 is_div;
    logic                 is_signed;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_trial;
    logic                 div_ok;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   prod_neg;
    logic [WIDTH-1:0]     fix_hi;
    logic [WIDTH-1:0]     fix_lo;

    assign in_ready = (state == ST_IDLE);
    assign busy     = ~in_ready;

    // Single-cycle result selection.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_XOR:  alu_res = data_in1 ^ data_in2;
            OP_SLL:  alu_res = data_in2 << shift_amount;
            OP_SRL:  alu_res = data_in2 >> shift_amount;
            OP_SRA:  alu_res = $signed(data_in2) >>> shift_amount;
            OP_ADD:  alu_res = data_in1 + data_in2;
            OP_SUB:  alu_res = data_in1 - data_in2;
            OP_OR:   alu_res = data_in1 | data_in2;
            OP_NOR:  alu_res = ~(data_in1 | data_in2);
            OP_AND:  alu_res = data_in1 & data_in2;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(data_in1) < $signed(data_in2))};
            OP_BEQ:  alu_res = {{(WIDTH-1){1'b0}}, (data_in1 == data_in2)};
            OP_BNE:  alu_res = {{(WIDTH-1){1'b0}}, (data_in1 != data_in2)};
            OP_BLEZ: alu_res = {{(WIDTH-1){1'b0}}, (data_in1[WIDTH-1] | (data_in1 == '0))};
            OP_BGTZ: alu_res = {{(WIDTH-1){1'b0}}, (~data_in1[WIDTH-1] & (data_in1 != '0))};
            OP_BGEZ: alu_res = {{(WIDTH-1){1'b0}}, ~data_in1[WIDTH-1]};
            OP_LUI:  alu_res = data_in2;
            OP_SLLV: alu_res = data_in2 << data_in1[SHAMT_W-1:0];
            OP_SRLV: alu_res = data_in2 >> data_in1[SHAMT_W-1:0];
            OP_SRAV: alu_res = $signed(data_in2) >>> data_in1[SHAMT_W-1:0];
            default: alu_res = '0;
        endcase
    end

    // Operand decode for the iterative path: magnitudes plus sign flags.
    always_comb begin
        is_mul    = (alu_op == OP_MULT) || (alu_op == OP_MULTU);
        is_div    = (alu_op == OP_DIV)  || (alu_op == OP_DIVU);
        is_signed = (alu_op == OP_MULT) || (alu_op == OP_DIV);
        a_neg     = is_signed & data_in1[WIDTH-1];
        b_neg     = is_signed & data_in2[WIDTH-1];
        mag_a     = a_neg ? -data_in1 : data_in1;
        mag_b     = b_neg ? -data_in2 : data_in2;
    end

    // One shift-add or restoring-divide step per RUN cycle.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd};
        div_ok    = ~div_trial[WIDTH];
    end

    // Sign correction applied in FIX; divide-by-zero keeps the raw quotient of all ones.
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_neg = -prod;
        fix_hi   = neg_hi ? -acc_hi : acc_hi;
        fix_lo   = acc_lo;
        if (!op_div) begin
            {fix_hi, fix_lo} = neg_lo ? prod_neg : prod;
        end else if (dbz_pend) begin
            fix_lo = '1;
        end else begin
            fix_lo = neg_lo ? -acc_lo : acc_lo;
        end
    end

    // Control FSM and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            op_div      <= 1'b0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            dbz_pend    <= 1'b0;
            opnd        <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            result      <= '0;
            hi          <= '0;
            lo          <= '0;
            zero        <= 1'b1;
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        div_by_zero <= 1'b0;
                        if (is_mul || is_div) begin
                            state    <= ST_RUN;
                            cnt      <= '0;
                            op_div   <= is_div;
                            neg_lo   <= a_neg ^ b_neg;
                            neg_hi   <= a_neg;
                            dbz_pend <= is_div && (data_in2 == '0);
                            opnd     <= is_div ? mag_b : mag_a;
                            acc_hi   <= '0;
                            acc_lo   <= is_div ? mag_a : mag_b;
                        end else begin
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (op_div) begin
                        acc_hi <= div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    if (cnt == LAST_ITER) begin
                        state <= ST_FIX;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_FIX: begin
                    hi          <= fix_hi;
                    lo          <= fix_lo;
                    result      <= fix_lo;
                    zero        <= (fix_lo == '0);
                    div_by_zero <= dbz_pend;
                    out_valid   <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;

    localparam int W = 32;

    localparam logic [4:0] XOR_ = 5'b00000, SLL_ = 5'b00001, SRL_ = 5'b00010, SRA_ = 5'b00011;
    localparam logic [4:0] ADD_ = 5'b00100, SUB_ = 5'b00101, MULT_ = 5'b00110, DIV_ = 5'b00111;
    localparam logic [4:0] OR_ = 5'b01000, NOR_ = 5'b01001, AND_ = 5'b01010, SLT_ = 5'b01011;
    localparam logic [4:0] BEQ_ = 5'b01101, BNE_ = 5'b01110, BLEZ_ = 5'b01111, BGTZ_ = 5'b10000;
    localparam logic [4:0] BGEZ_ = 5'b10001, LUI_ = 5'b10010, MULTU_ = 5'b10011, DIVU_ = 5'b10100;
    localparam logic [4:0] SLLV_ = 5'b11001, SRLV_ = 5'b11010, SRAV_ = 5'b11011;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    alu_op;
    logic [W-1:0]  data_in1;
    logic [W-1:0]  data_in2;
    logic [4:0]    shift_amount;
    logic          out_valid;
    logic [W-1:0]  result;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          zero;
    logic          div_by_zero;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    multicycle_alu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_op       (alu_op),
        .data_in1     (data_in1),
        .data_in2     (data_in2),
        .shift_amount (shift_amount),
        .out_valid    (out_valid),
        .result       (result),
        .hi           (hi),
        .lo           (lo),
        .zero         (zero),
        .div_by_zero  (div_by_zero),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Arithmetic shift right written as logical shift plus sign fill.
    function automatic logic [W-1:0] sra(input logic [W-1:0] v, input logic [4:0] s);
        logic [W-1:0] ones;
        logic [W-1:0] r;
        ones = '1;
        r = v >> s;
        if (v[W-1]) r = r | ~(ones >> s);
        return r;
    endfunction

    function automatic logic [W-1:0] ref_simple(input logic [4:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b, input logic [4:0] sh);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (op)
            XOR_:  return a ^ b;
            SLL_:  return b << sh;
            SRL_:  return b >> sh;
            SRA_:  return sra(b, sh);
            ADD_:  return a + b;
            SUB_:  return a - b;
            OR_:   return a | b;
            NOR_:  return ~(a | b);
            AND_:  return a & b;
            SLT_:  return (sa < sb) ? 32'd1 : 32'd0;
            BEQ_:  return (a == b) ? 32'd1 : 32'd0;
            BNE_:  return (a != b) ? 32'd1 : 32'd0;
            BLEZ_: return (sa <= 0) ? 32'd1 : 32'd0;
            BGTZ_: return (sa > 0) ? 32'd1 : 32'd0;
            BGEZ_: return (sa >= 0) ? 32'd1 : 32'd0;
            LUI_:  return b;
            SLLV_: return b << a[4:0];
            SRLV_: return b >> a[4:0];
            SRAV_: return sra(b, a[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    task automatic ref_muldiv(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rdz);
        int sa;
        int sb;
        longint p;
        logic [63:0] up;
        sa  = a;
        sb  = b;
        rdz = 1'b0;
        rh  = '0;
        rl  = '0;
        if (op == MULT_) begin
            p  = longint'(sa) * longint'(sb);
            up = p;
            {rh, rl} = up;
        end else if (op == MULTU_) begin
            up = {32'd0, a} * {32'd0, b};
            {rh, rl} = up;
        end else if (b == 0) begin
            rl  = '1;
            rh  = a;
            rdz = 1'b1;
        end else if (op == DIV_) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                rl = a;
                rh = '0;
            end else begin
                rl = sa / sb;
                rh = sa % sb;
            end
        end else begin
            rl = a / b;
            rh = a % b;
        end
    endtask

    function automatic logic [W-1:0] rv();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op and check its completion against the model.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [4:0] sh);
        logic [W-1:0] er;
        logic [W-1:0] eh;
        logic [W-1:0] el;
        logic         edz;
        int           n;
        logic         seen;
        alu_op       = op;
        data_in1     = a;
        data_in2     = b;
        shift_amount = sh;
        in_valid     = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!(op inside {MULT_, MULTU_, DIV_, DIVU_})) begin
            er = ref_simple(op, a, b, sh);
            chk($sformatf("%s.out_valid", tag), out_valid, 1'b1);
            chk($sformatf("%s.result", tag), result, er);
            chk($sformatf("%s.zero", tag), zero, (er == 0));
            chk($sformatf("%s.hi_hold", tag), hi, exp_hi);
            chk($sformatf("%s.lo_hold", tag), lo, exp_lo);
            chk($sformatf("%s.dbz", tag), div_by_zero, 1'b0);
            chk($sformatf("%s.in_ready", tag), in_ready, 1'b1);
        end else begin
            ref_muldiv(op, a, b, eh, el, edz);
            n    = 0;
            seen = 1'b0;
            while (!seen && n < W + 8) begin
                if (out_valid) begin
                    seen = 1'b1;
                end else begin
                    chk($sformatf("%s.ready_low", tag), {busy, in_ready}, 2'b10);
                    in_valid = 1'($urandom_range(0, 1));
                    alu_op   = ADD_;
                    data_in1 = $urandom;
                    data_in2 = $urandom;
                    @(posedge clk); #1;
                    n++;
                end
            end
            in_valid = 1'b0;
            chk($sformatf("%s.completed", tag), seen, 1'b1);
            // A simple op's strobe is sampled right after its accept edge and counts as 1 cycle.
            chk($sformatf("%s.latency", tag), n + 1, W + 2);
            chk($sformatf("%s.hi", tag), hi, eh);
            chk($sformatf("%s.lo", tag), lo, el);
            chk($sformatf("%s.result", tag), result, el);
            chk($sformatf("%s.zero", tag), zero, (el == 0));
            chk($sformatf("%s.dbz", tag), div_by_zero, edz);
            chk($sformatf("%s.in_ready", tag), in_ready, 1'b1);
            exp_hi = eh;
            exp_lo = el;
        end
    endtask

    logic [4:0] simple_ops [24] = '{XOR_, SLL_, SRL_, SRA_, ADD_, SUB_, OR_, NOR_, AND_, SLT_,
                                    BEQ_, BNE_, BLEZ_, BGTZ_, BGEZ_, LUI_, SLLV_, SRLV_, SRAV_,
                                    5'b01100, 5'b10101, 5'b11000, 5'b11111, 5'b10110};
    logic [4:0] iter_ops [4] = '{MULT_, MULTU_, DIV_, DIVU_};

    initial begin
        int ov_seen;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        alu_op       = '0;
        data_in1     = '0;
        data_in2     = '0;
        shift_amount = '0;
        #12;
        chk("reset.out_valid", out_valid, 1'b0);
        chk("reset.in_ready", in_ready, 1'b1);
        chk("reset.busy", busy, 1'b0);
        chk("reset.result", result, 32'd0);
        chk("reset.hilo", {hi, lo}, 64'd0);
        chk("reset.zero", zero, 1'b1);
        chk("reset.dbz", div_by_zero, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases, back-to-back single-cycle ops.
        run_op("add_ovf", ADD_, 32'h7FFF_FFFF, 32'h1, 5'd0);
        run_op("sub_zero", SUB_, 32'd5, 32'd5, 5'd0);
        run_op("srav", SRAV_, 32'd4, 32'hF000_0000, 5'd0);
        run_op("slt_neg", SLT_, 32'hFFFF_FFFF, 32'd1, 5'd0);
        run_op("bgez_min", BGEZ_, 32'h8000_0000, 32'd0, 5'd0);
        run_op("blez_zero", BLEZ_, 32'd0, 32'd0, 5'd0);
        run_op("undef_op", 5'b01100, 32'h1234_5678, 32'h1, 5'd3);
        @(posedge clk); #1;
        chk("idle.out_valid", out_valid, 1'b0);

        run_op("mult_neg", MULT_, 32'hFFFF_FFFD, 32'd5, 5'd0);
        run_op("multu_max", MULTU_, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        run_op("and_after_mul", AND_, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
        run_op("div_neg", DIV_, 32'hFFFF_FFF9, 32'd2, 5'd0);
        run_op("div_ovf", DIV_, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        run_op("div_sdz", DIV_, 32'hFFFF_FFF8, 32'd0, 5'd0);
        run_op("divu_dz", DIVU_, 32'd9, 32'd0, 5'd0);

        // Reset in the middle of RUN aborts the op.
        alu_op   = MULT_;
        data_in1 = 32'd1234;
        data_in2 = 32'd5678;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("midrun.busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", out_valid, 1'b0);
        chk("midrst.in_ready", in_ready, 1'b1);
        chk("midrst.result", result, 32'd0);
        chk("midrst.hilo", {hi, lo}, 64'd0);
        chk("midrst.zero", zero, 1'b1);
        chk("midrst.dbz", div_by_zero, 1'b0);
        exp_hi = '0;
        exp_lo = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ov_seen = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            if (out_valid) ov_seen++;
        end
        chk("midrst.no_out_valid", ov_seen, 0);
        chk("midrst.ready_after", in_ready, 1'b1);
        run_op("mult_after_rst", MULT_, 32'h0001_0003, 32'hFFFF_0007, 5'd0);

        // Randomized single-cycle ops.
        for (int i = 0; i < 60; i++) begin
            run_op("rnd_simple", simple_ops[$urandom_range(0, 23)], rv(), rv(), 5'($urandom));
        end

        // Randomized mul/div, each followed by a simple op checking hi/lo hold.
        for (int i = 0; i < 16; i++) begin
            run_op("rnd_iter", iter_ops[$urandom_range(0, 3)], rv(), rv(), 5'd0);
            run_op("rnd_hold", simple_ops[$urandom_range(0, 18)], rv(), rv(), 5'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
